lc3_instr_encoder: RTL and testbench

- Encodes LC-3 instructions: takes an opcode, register fields and a 16-bit signed operand, and produces a 16-bit instruction word.
- It is the inverse of the `sext` immediate path. The operand is narrowed to the opcode's field width, with a range check and optional saturation.
- Sits between the test/program-loader logic and the SLC-3 memory image, so the bench can generate instructions and check them against the `sext` decode path.
- Uses a valid/ready handshake on both sides and keeps a saturating error counter.

---
 rtl/lc3_instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_lc3_instr_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_instr_encoder.sv
// LC-3 instruction encoder: narrows a 16-bit signed operand to the opcode's
// field width (range check, optional clamp) and packs a 16-bit instruction.
//
// Handshake: a request transfers on a rising edge with in_valid & in_ready;
// a result transfers on a rising edge with out_valid & out_ready. Once
// asserted, out_valid stays high and instr/range_err stay stable until the
// transfer. in_ready is high only in IDLE; there is no request queueing.
module lc3_instr_encoder #(
  parameter int SATURATE  = 0,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [2:0]           dr,
  input  logic [2:0]           sr1,
  input  logic [2:0]           sr2,
  input  logic                 imm_mode,
  input  logic [2:0]           nzp,
  input  logic [15:0]          value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          instr,
  output logic                 range_err,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam bit SAT = (SATURATE != 0);

  logic [1:0]           state_q, state_d;
  logic [3:0]           op_q;
  logic [2:0]           dr_q, sr1_q, sr2_q, nzp_q;
  logic                 imm_mode_q;
  logic [15:0]          value_q;
  logic [15:0]          instr_q, instr_d;
  logic                 range_err_q, range_err_d;
  logic [ERR_WIDTH-1:0] err_count_q;

  logic                 fit5, fit6, fit9, fit11, fit8u;
  logic [4:0]           imm5;
  logic [5:0]           off6;
  logic [8:0]           off9;
  logic [10:0]          off11;
  logic [7:0]           vect8;
  logic                 xfer_out;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign instr     = instr_q;
  assign range_err = range_err_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;
  assign xfer_out  = out_valid & out_ready;

  // Operand narrowing: a value fits W signed bits when bits [15:W-1] all agree
  always_comb begin
    fit5  = (&value_q[15:4])  | ~(|value_q[15:4]);
    fit6  = (&value_q[15:5])  | ~(|value_q[15:5]);
    fit9  = (&value_q[15:8])  | ~(|value_q[15:8]);
    fit11 = (&value_q[15:10]) | ~(|value_q[15:10]);
    fit8u = ~(|value_q[15:8]);
    imm5  = value_q[4:0];
    off6  = value_q[5:0];
    off9  = value_q[8:0];
    off11 = value_q[10:0];
    vect8 = value_q[7:0];
    if (SAT) begin
      if (!fit5)  imm5  = value_q[15] ? 5'b10000 : 5'b01111;
      if (!fit6)  off6  = value_q[15] ? 6'b100000 : 6'b011111;
      if (!fit9)  off9  = value_q[15] ? 9'h100 : 9'h0FF;
      if (!fit11) off11 = value_q[15] ? 11'h400 : 11'h3FF;
      if (!fit8u) vect8 = value_q[15] ? 8'h00 : 8'hFF;
    end
  end

  // Instruction packing and range error by opcode
  always_comb begin
    instr_d     = 16'h0000;
    range_err_d = 1'b0;
    case (op_q)
      4'b0001, 4'b0101: begin
        if (imm_mode_q) begin
          instr_d     = {op_q, dr_q, sr1_q, 1'b1, imm5};
          range_err_d = ~fit5;
        end else begin
          instr_d     = {op_q, dr_q, sr1_q, 3'b000, sr2_q};
        end
      end
      4'b0000: begin
        instr_d     = {op_q, nzp_q, off9};
        range_err_d = ~fit9;
      end
      4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b1110: begin
        instr_d     = {op_q, dr_q, off9};
        range_err_d = ~fit9;
      end
      4'b0110, 4'b0111: begin
        instr_d     = {op_q, dr_q, sr1_q, off6};
        range_err_d = ~fit6;
      end
      4'b0100: begin
        instr_d     = {op_q, 1'b1, off11};
        range_err_d = ~fit11;
      end
      4'b1100: instr_d = {op_q, 3'b000, sr1_q, 6'b000000};
      4'b1001: instr_d = {op_q, dr_q, sr1_q, 6'b111111};
      4'b1000: instr_d = 16'h8000;
      4'b1111: begin
        instr_d     = {op_q, 4'b0000, vect8};
        range_err_d = ~fit8u;
      end
      default: begin
        instr_d     = 16'hD000;
        range_err_d = 1'b1;
      end
    endcase
  end

  // Next-state logic for IDLE -> CHECK -> OUT -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CHECK;
      S_CHECK: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture, result registers and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 4'h0;
      dr_q        <= 3'h0;
      sr1_q       <= 3'h0;
      sr2_q       <= 3'h0;
      nzp_q       <= 3'h0;
      imm_mode_q  <= 1'b0;
      value_q     <= 16'h0000;
      instr_q     <= 16'h0000;
      range_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) begin
        op_q       <= op;
        dr_q       <= dr;
        sr1_q      <= sr1;
        sr2_q      <= sr2;
        nzp_q      <= nzp;
        imm_mode_q <= imm_mode;
        value_q    <= value;
      end
      if (state_q == S_CHECK) begin
        instr_q     <= instr_d;
        range_err_q <= range_err_d;
      end
      if (xfer_out && range_err_q && !(&err_count_q)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_instr_encoder.sv
// Directed bench for lc3_instr_encoder: a truncating instance, a clamping
// instance and a 2-bit error counter instance share the same stimulus.
module tb_lc3_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [2:0]  dr = 3'h0, sr1 = 3'h0, sr2 = 3'h0, nzp = 3'h0;
  logic        imm_mode = 1'b0;
  logic [15:0] value = 16'h0000;

  logic        in_ready_a, out_valid_a, range_err_a;
  logic [15:0] instr_a;
  logic [7:0]  err_count_a;
  logic [1:0]  dbg_a;

  logic        in_ready_s, out_valid_s, range_err_s;
  logic [15:0] instr_s;
  logic [7:0]  err_count_s;
  logic [1:0]  dbg_s;

  logic        in_ready_e, out_valid_e, range_err_e;
  logic [15:0] instr_e;
  logic [1:0]  err_count_e;
  logic [1:0]  dbg_e;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err8 = 0;
  int exp_err2 = 0;

  // Clock
  always #5 clk = ~clk;

  lc3_instr_encoder #(.SATURATE(0), .ERR_WIDTH(8)) u_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .op(op), .dr(dr), .sr1(sr1), .sr2(sr2), .imm_mode(imm_mode), .nzp(nzp),
    .value(value), .out_valid(out_valid_a), .out_ready(out_ready),
    .instr(instr_a), .range_err(range_err_a), .err_count(err_count_a),
    .dbg_state(dbg_a)
  );

  lc3_instr_encoder #(.SATURATE(1), .ERR_WIDTH(8)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .dr(dr), .sr1(sr1), .sr2(sr2), .imm_mode(imm_mode), .nzp(nzp),
    .value(value), .out_valid(out_valid_s), .out_ready(out_ready),
    .instr(instr_s), .range_err(range_err_s), .err_count(err_count_s),
    .dbg_state(dbg_s)
  );

  lc3_instr_encoder #(.SATURATE(0), .ERR_WIDTH(2)) u_e2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e),
    .op(op), .dr(dr), .sr1(sr1), .sr2(sr2), .imm_mode(imm_mode), .nzp(nzp),
    .value(value), .out_valid(out_valid_e), .out_ready(out_ready),
    .instr(instr_e), .range_err(range_err_e), .err_count(err_count_e),
    .dbg_state(dbg_e)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] t_op, input logic [2:0] t_dr, input logic [2:0] t_sr1,
                       input logic [2:0] t_sr2, input logic t_imm, input logic [2:0] t_nzp,
                       input logic [15:0] t_val);
    op = t_op; dr = t_dr; sr1 = t_sr1; sr2 = t_sr2;
    imm_mode = t_imm; nzp = t_nzp; value = t_val;
    in_valid = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ":err8"}, {24'h0, err_count_a}, exp_err8);
    check({tag, ":err8s"}, {24'h0, err_count_s}, exp_err8);
    check({tag, ":err2"}, {30'h0, err_count_e}, exp_err2);
  endtask

  task automatic model_transfer(input logic x_err);
    if (x_err) begin
      if (exp_err8 < 255) exp_err8++;
      if (exp_err2 < 3) exp_err2++;
    end
  endtask

  // Full transaction: accept, CHECK, OUT with results, transfer
  task automatic req(input string tag, input logic [3:0] t_op, input logic [2:0] t_dr,
                     input logic [2:0] t_sr1, input logic [2:0] t_sr2, input logic t_imm,
                     input logic [2:0] t_nzp, input logic [15:0] t_val,
                     input logic [15:0] x_ins, input logic [15:0] x_sat, input logic x_err);
    @(negedge clk);
    check({tag, ":in_ready"}, {31'h0, in_ready_a}, 1);
    drive(t_op, t_dr, t_sr1, t_sr2, t_imm, t_nzp, t_val);
    @(negedge clk);
    in_valid = 1'b0;
    value = ~t_val;
    check({tag, ":check_state"}, {28'h0, out_valid_a, in_ready_a, dbg_a}, {28'h0, 2'b00, 2'd1});
    @(negedge clk);
    check({tag, ":out_valid"}, {31'h0, out_valid_a}, 1);
    check({tag, ":instr"}, {16'h0, instr_a}, {16'h0, x_ins});
    check({tag, ":range_err"}, {31'h0, range_err_a}, {31'h0, x_err});
    check({tag, ":instr_sat"}, {16'h0, instr_s}, {16'h0, x_sat});
    check({tag, ":range_err_sat"}, {31'h0, range_err_s}, {31'h0, x_err});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_transfer(x_err);
    check({tag, ":post_xfer"}, {30'h0, out_valid_a, in_ready_a}, {30'h0, 2'b01});
    check_counts(tag);
  endtask

  logic [15:0] held_instr;

  initial begin
    // Reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:in_ready", {31'h0, in_ready_a}, 1);
    check("rst:out_valid", {31'h0, out_valid_a}, 0);
    check("rst:instr", {16'h0, instr_a}, 0);
    check("rst:range_err", {31'h0, range_err_a}, 0);
    check_counts("rst");
    reset = 1'b0;

    //   tag          op     dr    sr1   sr2   imm   nzp    value     trunc     sat    err
    req("add_imm",  4'b0001, 3'd1, 3'd2, 3'd0, 1'b1, 3'd0, 16'hFFF0, 16'h12B0, 16'h12B0, 1'b0);
    req("add_oor",  4'b0001, 3'd1, 3'd2, 3'd0, 1'b1, 3'd0, 16'h0010, 16'h12B0, 16'h12AF, 1'b1);
    req("and_imm",  4'b0101, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 16'h000F, 16'h502F, 16'h502F, 1'b0);
    req("add_reg",  4'b0001, 3'd4, 3'd5, 3'd6, 1'b0, 3'd0, 16'h7FFF, 16'h1946, 16'h1946, 1'b0);
    req("ldr_min",  4'b0110, 3'd3, 3'd4, 3'd0, 1'b0, 3'd0, 16'hFFE0, 16'h6720, 16'h6720, 1'b0);
    req("ldr_oor",  4'b0110, 3'd3, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0020, 16'h6720, 16'h671F, 1'b1);
    req("ldr_one",  4'b0110, 3'd3, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0001, 16'h6701, 16'h6701, 1'b0);
    req("str",      4'b0111, 3'd1, 3'd2, 3'd0, 1'b0, 3'd0, 16'h001F, 16'h729F, 16'h729F, 1'b0);
    req("br_min",   4'b0000, 3'd0, 3'd0, 3'd0, 1'b0, 3'd7, 16'hFF00, 16'h0F00, 16'h0F00, 1'b0);
    req("br_oor",   4'b0000, 3'd0, 3'd0, 3'd0, 1'b0, 3'd7, 16'hFEFF, 16'h0EFF, 16'h0F00, 1'b1);
    req("lea_max",  4'b1110, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 16'h00FF, 16'hEAFF, 16'hEAFF, 1'b0);
    req("jsr_min",  4'b0100, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'hFC00, 16'h4C00, 16'h4C00, 1'b0);
    req("jsr_oor",  4'b0100, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0400, 16'h4C00, 16'h4BFF, 1'b1);
    req("trap",     4'b1111, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0025, 16'hF025, 16'hF025, 1'b0);
    req("trap_hi",  4'b1111, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0125, 16'hF025, 16'hF0FF, 1'b1);
    req("trap_neg", 4'b1111, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'hFF80, 16'hF080, 16'hF000, 1'b1);
    req("reserved", 4'b1101, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hD000, 16'hD000, 1'b1);
    req("jmp",      4'b1100, 3'd2, 3'd7, 3'd0, 1'b0, 3'd0, 16'h8000, 16'hC1C0, 16'hC1C0, 1'b0);
    req("not",      4'b1001, 3'd2, 3'd5, 3'd0, 1'b0, 3'd0, 16'h7FFF, 16'h957F, 16'h957F, 1'b0);
    req("rti",      4'b1000, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'hFFFF, 16'h8000, 16'h8000, 1'b0);

    // Backpressure: erroring LDR held in OUT for 5 cycles with in_valid pressing
    @(negedge clk);
    drive(4'b0110, 3'd3, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0020);
    repeat (2) @(negedge clk);
    held_instr = instr_a;
    drive(4'b1111, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0021);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp:hold", {12'h0, out_valid_a, in_ready_a, range_err_a, 1'b0, instr_a},
            {12'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h6720});
      check("bp:stable", {16'h0, instr_a}, {16'h0, held_instr});
      check_counts("bp");
    end
    // Release with in_valid still high: return to IDLE, accept next cycle
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_transfer(1'b1);
    check("bp:idle", {28'h0, out_valid_a, in_ready_a, dbg_a}, {28'h0, 2'b01, 2'd0});
    check_counts("bp_xfer");
    @(negedge clk);
    in_valid = 1'b0;
    check("bp:accepted", {30'h0, dbg_a}, 1);
    @(negedge clk);
    check("bp:next_instr", {16'h0, instr_a}, 32'hF021);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_transfer(1'b0);
    check_counts("bp_next");

    // Reset while in OUT drops the transaction and clears the counter
    @(negedge clk);
    drive(4'b1101, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out:pre", {31'h0, out_valid_a}, 1);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    exp_err8 = 0;
    exp_err2 = 0;
    check("rst_out:flags", {30'h0, out_valid_a, in_ready_a}, {30'h0, 2'b01});
    check_counts("rst_out");

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      req("err_sat", 4'b1101, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hD000, 16'hD000, 1'b1);
    end
    check("err_sat:final", {30'h0, err_count_e}, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
